// File: rtl/rvv_uop_sequencer_pkg.sv
// Shared types and encodings for the RVV micro-op sequencer and its count unit.
package rvv_uop_sequencer_pkg;

  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_RSV = 3'b100,
    LMUL_F4  = 3'b110,
    LMUL_F2  = 3'b111
  } lmul_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010
  } sew_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  // vlmul value with no defined group size
  localparam logic [2:0] LMUL_RESERVED = 3'b100;
  // largest vsew encoding that names a supported element width
  localparam logic [2:0] SEW_MAX_LEGAL = 3'b010;
  // log2 limits: element width up to 32 bits, register group up to 8
  localparam logic [3:0]        EEW_LOG_MAX  = 4'd2;
  localparam logic signed [3:0] EMUL_LOG_MAX = 4'sd3;

endpackage

// File: rtl/rvv_uop_count.sv
// Combinational legality check and uop count for one vector instruction.
// Everything is a power of two, so the division by elements-per-register
// is a round-up add followed by a right shift.
module rvv_uop_count
  import rvv_uop_sequencer_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input  logic [2:0]      vlmul,
  input  logic [2:0]      vsew,
  input  logic            widen,
  input  logic [VL_W-1:0] vl,
  output logic            illegal,
  output logic [3:0]      epr_log,
  output logic [3:0]      count
);

  localparam int VLENB_LOG = $clog2(VLEN / 8);
  localparam logic [VL_W:0] ONE_X = 1;

  logic [3:0]        eew_log;
  logic signed [3:0] emul_log;
  logic [1:0]        emul_pos;
  logic [3:0]        nmax;
  logic [VL_W:0]     vl_round;
  logic [VL_W:0]     n_regs;

  // Decode widths, check legality and clamp the register count to the group size
  always_comb begin
    eew_log  = {1'b0, vsew} + {3'b000, widen};
    emul_log = signed'({vlmul[2], vlmul}) + signed'({3'b000, widen});
    illegal  = (vlmul == LMUL_RESERVED) || (vsew > SEW_MAX_LEGAL) ||
               (eew_log > EEW_LOG_MAX) || (emul_log > EMUL_LOG_MAX);
    epr_log  = 4'(VLENB_LOG) - eew_log;
    // fractional LMUL still occupies one register
    emul_pos = emul_log[3] ? 2'd0 : emul_log[1:0];
    nmax     = 4'd1 << emul_pos;
    vl_round = {1'b0, vl} + ((ONE_X << epr_log) - ONE_X);
    n_regs   = vl_round >> epr_log;
    count    = (n_regs < {{(VL_W-3){1'b0}}, nmax}) ? n_regs[3:0] : nmax;
  end

endmodule

// File: rtl/rvv_uop_sequencer.sv
// Splits an accepted vector instruction into one uop per destination
// register of its group, with a valid/ready handshake toward the backend.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for an instruction; inst_ready high unless flush
//   ST_SEQ  | issuing uops for the latched instruction
module rvv_uop_sequencer
  import rvv_uop_sequencer_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VL_W = $clog2(VLEN) + 1,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [2:0]      inst_vlmul,
  input  logic [2:0]      inst_vsew,
  input  logic            inst_widen,
  input  logic [VL_W-1:0] inst_vl,
  input  logic [ID_W-1:0] inst_id,
  output logic            inst_illegal,
  output logic            inst_done,
  output logic            uop_valid,
  input  logic            uop_ready,
  output logic [2:0]      uop_idx,
  output logic [VL_W-1:0] uop_elem_base,
  output logic            uop_last,
  output logic [ID_W-1:0] uop_id,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [2:0]      counter_q;
  logic [3:0]      count_q;
  logic [3:0]      epr_log_q;
  logic [ID_W-1:0] id_q;
  logic            done_q;
  logic            illegal_q;

  logic            cnt_illegal;
  logic [3:0]      cnt_epr_log;
  logic [3:0]      cnt_count;

  logic            seq;
  logic            is_last;
  logic            accept;
  logic            uop_fire;
  logic            last_fire;
  logic            vl_zero;

  rvv_uop_count #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_count (
    .vlmul   (inst_vlmul),
    .vsew    (inst_vsew),
    .widen   (inst_widen),
    .vl      (inst_vl),
    .illegal (cnt_illegal),
    .epr_log (cnt_epr_log),
    .count   (cnt_count)
  );

  assign seq     = (state_q == ST_SEQ);
  assign is_last = ({1'b0, counter_q} == (count_q - 4'd1));
  assign vl_zero = (inst_vl == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshakes; flush wins over both the uop and instruction handshakes
  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    uop_valid  = 1'b0;
    accept     = 1'b0;
    uop_fire   = 1'b0;
    last_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inst_ready = ~flush;
        accept     = inst_valid & ~flush;
        if (accept && !cnt_illegal && !vl_zero) state_d = ST_SEQ;
      end
      ST_SEQ: begin
        uop_valid = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (uop_ready) begin
          uop_fire = 1'b1;
          if (is_last) begin
            last_fire = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch, uop counter and the one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      count_q   <= '0;
      epr_log_q <= '0;
      id_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= (accept & ~cnt_illegal & vl_zero) | last_fire;
      illegal_q <= accept & cnt_illegal;
      if (accept && !cnt_illegal) begin
        count_q   <= cnt_count;
        epr_log_q <= cnt_epr_log;
        id_q      <= inst_id;
        counter_q <= '0;
      end else if (last_fire || (seq && flush)) begin
        counter_q <= '0;
      end else if (uop_fire) begin
        counter_q <= counter_q + 3'd1;
      end
    end
  end

  // uop fields read zero outside SEQ so reset and idle look identical downstream
  assign uop_idx       = seq ? counter_q : 3'd0;
  assign uop_elem_base = seq ? (VL_W'(counter_q) << epr_log_q) : '0;
  assign uop_last      = seq & is_last;
  assign uop_id        = seq ? id_q : '0;
  assign busy          = seq;
  assign inst_done     = done_q;
  assign inst_illegal  = illegal_q;

endmodule

// File: tb/tb_rvv_uop_sequencer.sv
// Directed bench for rvv_uop_sequencer at VLEN=128 with hand-computed expectations.
module tb_rvv_uop_sequencer;
  import rvv_uop_sequencer_pkg::*;

  localparam int VLEN = 128;
  localparam int VL_W = 8;
  localparam int ID_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            inst_valid;
  logic            inst_ready;
  logic [2:0]      inst_vlmul;
  logic [2:0]      inst_vsew;
  logic            inst_widen;
  logic [VL_W-1:0] inst_vl;
  logic [ID_W-1:0] inst_id;
  logic            inst_illegal;
  logic            inst_done;
  logic            uop_valid;
  logic            uop_ready;
  logic [2:0]      uop_idx;
  logic [VL_W-1:0] uop_elem_base;
  logic            uop_last;
  logic [ID_W-1:0] uop_id;
  logic            busy;

  int n_checks = 0;
  int n_pass   = 0;

  rvv_uop_sequencer #(.VLEN(VLEN), .VL_W(VL_W), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_vlmul    (inst_vlmul),
    .inst_vsew     (inst_vsew),
    .inst_widen    (inst_widen),
    .inst_vl       (inst_vl),
    .inst_id       (inst_id),
    .inst_illegal  (inst_illegal),
    .inst_done     (inst_done),
    .uop_valid     (uop_valid),
    .uop_ready     (uop_ready),
    .uop_idx       (uop_idx),
    .uop_elem_base (uop_elem_base),
    .uop_last      (uop_last),
    .uop_id        (uop_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer one instruction for one cycle; returns one cycle after acceptance
  task automatic issue(input logic [2:0] lmul, input logic [2:0] sew, input logic wid,
                       input int vl, input int id);
    inst_vlmul = lmul;
    inst_vsew  = sew;
    inst_widen = wid;
    inst_vl    = VL_W'(vl);
    inst_id    = ID_W'(id);
    inst_valid = 1'b1;
    #1 check("inst_ready_offer", 32'(inst_ready), 1);
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  task automatic check_uop(input int i, input int n, input int epr, input int id);
    check("uop_valid", 32'(uop_valid), 1);
    check("uop_idx", 32'(uop_idx), i);
    check("uop_elem_base", 32'(uop_elem_base), i * epr);
    check("uop_last", 32'(uop_last), (i == n - 1) ? 1 : 0);
    check("uop_id", 32'(uop_id), id);
    check("busy_seq", 32'(busy), 1);
    check("inst_ready_seq", 32'(inst_ready), 0);
    check("done_quiet_seq", 32'(inst_done), 0);
  endtask

  // consume n uops, optionally stalling stall_len cycles at index stall_at
  task automatic run_uops(input int n, input int epr, input int id,
                          input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        uop_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_uop(i, n, epr, id);
          step();
        end
        uop_ready = 1'b1;
      end
      check_uop(i, n, epr, id);
      step();
    end
    check("done_pulse", 32'(inst_done), 1);
    check("valid_after_last", 32'(uop_valid), 0);
    check("busy_after_last", 32'(busy), 0);
    check("illegal_quiet", 32'(inst_illegal), 0);
    check("ready_after_last", 32'(inst_ready), 1);
    step();
    check("done_one_cycle", 32'(inst_done), 0);
  endtask

  task automatic expect_illegal();
    check("illegal_pulse", 32'(inst_illegal), 1);
    check("illegal_no_uop", 32'(uop_valid), 0);
    check("illegal_ready", 32'(inst_ready), 1);
    check("illegal_not_busy", 32'(busy), 0);
    check("illegal_no_done", 32'(inst_done), 0);
    step();
    check("illegal_one_cycle", 32'(inst_illegal), 0);
    check("illegal_no_uop_later", 32'(uop_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    inst_valid = 1'b0;
    inst_vlmul = '0;
    inst_vsew  = '0;
    inst_widen = 1'b0;
    inst_vl    = '0;
    inst_id    = '0;
    uop_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_inst_ready", 32'(inst_ready), 1);
    check("rst_uop_valid", 32'(uop_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(inst_done), 0);
    check("rst_illegal", 32'(inst_illegal), 0);
    check("rst_uop_idx", 32'(uop_idx), 0);
    check("rst_uop_base", 32'(uop_elem_base), 0);
    check("rst_uop_id", 32'(uop_id), 0);
    step();

    // LMUL2 SEW8 vl=32: 16 elems/reg -> 2 uops
    issue(LMUL_2, SEW_8, 1'b0, 32, 3);
    run_uops(2, 16, 3, -1, 0);

    // LMUL4 SEW16 vl=20: 8 elems/reg, ceil(20/8)=3
    issue(LMUL_4, SEW_16, 1'b0, 20, 9);
    run_uops(3, 8, 9, -1, 0);

    // widening LMUL8 -> EMUL 16 illegal
    issue(LMUL_8, SEW_8, 1'b1, 64, 5);
    expect_illegal();

    // widening SEW32 -> EEW 64 illegal
    issue(LMUL_1, SEW_32, 1'b1, 16, 6);
    expect_illegal();

    // reserved LMUL encoding
    issue(LMUL_RSV, SEW_8, 1'b0, 8, 2);
    expect_illegal();

    // plain SEW32 is legal: 4 elems/reg, vl=4 -> 1 uop
    issue(LMUL_1, SEW_32, 1'b0, 4, 12);
    run_uops(1, 4, 12, -1, 0);

    // LMUL1 SEW8 vl=40 capped at the group size of 1
    issue(LMUL_1, SEW_8, 1'b0, 40, 13);
    run_uops(1, 16, 13, -1, 0);

    // widening LMUL2 SEW8: EEW16 (8/reg), EMUL4, vl=30 -> 4 uops
    issue(LMUL_2, SEW_8, 1'b1, 30, 14);
    run_uops(4, 8, 14, -1, 0);

    // LMUL1/2 SEW8 vl=0 -> done only
    issue(LMUL_F2, SEW_8, 1'b0, 0, 7);
    check("vl0_done", 32'(inst_done), 1);
    check("vl0_no_illegal", 32'(inst_illegal), 0);
    check("vl0_no_uop", 32'(uop_valid), 0);
    check("vl0_idle", 32'(busy), 0);
    step();
    check("vl0_done_one_cycle", 32'(inst_done), 0);
    check("vl0_no_uop_later", 32'(uop_valid), 0);

    // LMUL1/2 SEW8 vl=5 -> single uop
    issue(LMUL_F2, SEW_8, 1'b0, 5, 8);
    run_uops(1, 16, 8, -1, 0);

    // LMUL8 SEW8 vl=128 with a 3-cycle stall at idx 3
    issue(LMUL_8, SEW_8, 1'b0, 128, 10);
    run_uops(8, 16, 10, 3, 3);

    // flush coincident with the idx-1 handshake of a 4-uop instruction
    issue(LMUL_4, SEW_8, 1'b0, 64, 11);
    check_uop(0, 4, 16, 11);
    step();
    check_uop(1, 4, 16, 11);
    flush = 1'b1;
    #1 check("flush_blocks_ready", 32'(inst_ready), 0);
    step();
    flush = 1'b0;
    check("flush_valid_drop", 32'(uop_valid), 0);
    check("flush_idle", 32'(busy), 0);
    check("flush_no_done", 32'(inst_done), 0);
    step();
    check("flush_no_done_later", 32'(inst_done), 0);
    issue(LMUL_2, SEW_8, 1'b0, 32, 4);
    run_uops(2, 16, 4, -1, 0);

    // flush in IDLE refuses an offered instruction
    inst_vlmul = LMUL_2;
    inst_vsew  = SEW_8;
    inst_widen = 1'b0;
    inst_vl    = VL_W'(32);
    inst_valid = 1'b1;
    flush      = 1'b1;
    #1 check("idle_flush_ready", 32'(inst_ready), 0);
    step();
    inst_valid = 1'b0;
    flush      = 1'b0;
    #1;
    check("idle_flush_not_busy", 32'(busy), 0);
    check("idle_flush_no_done", 32'(inst_done), 0);
    check("idle_flush_no_illegal", 32'(inst_illegal), 0);

    // reset mid-SEQ discards the instruction silently
    issue(LMUL_4, SEW_8, 1'b0, 64, 15);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(uop_valid), 0);
    check("midrst_done", 32'(inst_done), 0);
    check("midrst_ready", 32'(inst_ready), 1);
    check("midrst_uop_id", 32'(uop_id), 0);
    step();
    check("midrst_done_later", 32'(inst_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvv_uop_sequencer.md
RVV_UOP_SEQUENCER -- requirements
Module: rvv_uop_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register width in bits; VLENB = VLEN/8.
REQ-002 SHALL have parameter VL_W, default $clog2(VLEN)+1: vl field width.
REQ-003 SHALL have parameter ID_W, default 4: instruction tag width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port: flush  in  1  abort the current instruction.
REQ-008 SHALL have port: inst_valid  in  1  instruction offered.
REQ-009 SHALL have port: inst_ready  out  1  instruction accepted this cycle.
REQ-010 SHALL have port: inst_vlmul  in  3  LMUL encoding (110=1/4, 111=1/2, 000..011=1..8, 100 reserved).
REQ-011 SHALL have port: inst_vsew  in  3  SEW encoding (000=8, 001=16, 010=32, others reserved).
REQ-012 SHALL have port: inst_widen  in  1  destination EEW = 2*SEW.
REQ-013 SHALL have port: inst_vl  in  VL_W  vector length.
REQ-014 SHALL have port: inst_id  in  ID_W  instruction tag.
REQ-015 SHALL have port: inst_illegal  out  1  one-cycle pulse: accepted instruction rejected.
REQ-016 SHALL have port: inst_done  out  1  one-cycle pulse: instruction fully issued.
REQ-017 SHALL have port: uop_valid  out  1  uop offered.
REQ-018 SHALL have port: uop_ready  in  1  downstream accepts uop.
REQ-019 SHALL have port: uop_idx  out  3  register offset within group.
REQ-020 SHALL have port: uop_elem_base  out  VL_W  first element index of this uop.
REQ-021 SHALL have port: uop_last  out  1  final uop of the instruction.
REQ-022 SHALL have port: uop_id  out  ID_W  latched inst_id.
REQ-023 SHALL have port: busy  out  1  state is SEQ.

Function
REQ-024 SHALL implement states IDLE and SEQ; inst_ready = (state==IDLE) & ~flush.
REQ-025 SHALL compute eew_log = vsew + widen and emul_log = signed(vlmul) + widen.
REQ-026 SHALL flag illegal when vlmul==100, vsew>010, eew_log>2, or emul_log>3.
REQ-027 SHALL compute epr = VLENB >> eew_log, nmax = 1 << max(emul_log,0), and count = min(nmax, ceil(vl/epr)) using shifts only, no divider.
REQ-028 SHALL, on an accepted illegal instruction, pulse inst_illegal next cycle, emit no uop, and remain IDLE.
REQ-029 SHALL, on an accepted legal instruction with vl==0, pulse inst_done next cycle, emit no uop, and remain IDLE.
REQ-030 SHALL, on an accepted legal instruction with vl>0, latch count, epr and inst_id, clear the uop counter, and enter SEQ next cycle.
REQ-031 SHALL in SEQ drive uop_valid=1, uop_idx=counter, uop_elem_base=counter*epr, and uop_last=(counter==count-1).
REQ-032 SHALL hold all uop fields stable while uop_valid & ~uop_ready.
REQ-033 SHALL increment the counter on uop_valid & uop_ready; on the last handshake, enter IDLE and pulse inst_done next cycle.
REQ-034 SHALL allow at least one idle cycle between instructions (inst_ready=0 throughout SEQ).
REQ-035 SHALL on flush go to IDLE next cycle and drop uop_valid with no inst_done; flush overrides a same-cycle uop or inst handshake (uop handshake ignored, instruction not accepted).
REQ-036 SHALL keep inst_illegal and inst_done mutually exclusive and never asserted together with uop_valid in the same instruction's window.

Reset
REQ-037 SHALL on rst set state=IDLE, counter=0, and uop_valid, inst_illegal, inst_done, busy, uop_last, uop_idx, uop_elem_base and uop_id to 0; reset mid-SEQ discards the instruction with no pulses.
REQ-038 SHALL drive inst_ready=1 in the first cycle after rst deasserts, unless flush is asserted.

Structure
REQ-039 SHALL place the lmul_e, sew_e, and state enum and the reserved-encoding constants in a shared package imported by RTL and bench.
REQ-040 SHALL isolate the legality and count logic of REQ-025..027 in a combinational sub-module rvv_uop_count.

Verification (VLEN=128)
REQ-041 SHALL test: LMUL2, SEW8, vl=32, uop_ready=1 -> 2 uops, idx 0/1, elem_base 0/16, uop_last on idx 1, inst_done one cycle later.
REQ-042 SHALL test: LMUL4, SEW16, vl=20 -> 3 uops with elem_base 0/8/16, last on idx 2.
REQ-043 SHALL test: widen=1 with LMUL8, and separately SEW32 -> inst_illegal pulse, no uop_valid, inst_ready stays 1.
REQ-044 SHALL test: LMUL1/2, SEW8, vl=0 -> inst_done pulse only; vl=5 -> one uop, last=1.
REQ-045 SHALL test: LMUL8, SEW8, vl=128, with uop_ready low 3 cycles at idx 3 -> fields held stable, 8 uops total.
REQ-046 SHALL test: flush with a same-cycle uop handshake at idx 1 of a 4-uop instruction -> uop_valid=0 next cycle, no inst_done, next instruction restarts at idx 0.
